sram_controller: RTL and testbench

Multi-cycle bridge between the pipeline's MEM stage and a 16-bit-wide synchronous data SRAM that replaces the single-cycle 32-bit data memory. The block:
- accepts one word read or write per request;
- splits it into two halfword SRAM phases, low half first, each lasting `WAIT_CYCLES` cycles;
- drives `ready` low until the word completes, so the pipeline freezes.

---
 rtl/sram_controller_pkg.sv | 14 +
 rtl/sram_controller_if.sv | 32 +++
 rtl/sram_controller_phase_counter.sv | 28 ++
 rtl/sram_controller.sv | 124 ++++++++++++
 tb/tb_sram_controller.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 16-bit SRAM bridge.
package sram_ctrl_pkg;

  localparam int          HALF_W            = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request bus plus SRAM pins for the word-to-halfword bridge.
interface sram_controller_if #(
  parameter int SA_W = 7
);
  import sram_ctrl_pkg::*;

  // Request is "valid" while mem_read|mem_write is high; the source must hold
  // it unchanged until it samples ready=1 on a clock edge, which retires it.
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       address;
  logic [31:0]       data;
  logic [31:0]       mem_result;
  logic              ready;
  logic [SA_W-1:0]   sram_addr;
  logic [HALF_W-1:0] sram_dq_out;
  logic [HALF_W-1:0] sram_dq_in;
  logic              sram_we_n;
  logic              sram_oe_n;

  // master = pipeline plus SRAM device; slave = the controller.
  modport master (
    output mem_read, mem_write, address, data, sram_dq_in,
    input  mem_result, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
  );

  modport slave (
    input  mem_read, mem_write, address, data, sram_dq_in,
    output mem_result, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_controller_phase_counter.sv
// Modulo-WAIT_CYCLES counter timing each halfword phase; o_last flags the final cycle.
module phase_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  assign o_last = (r_cnt == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= o_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two WAIT_CYCLES-long halfword SRAM phases.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output state_t            o_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             r_state;
  state_t             w_next;
  logic               r_is_write;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_data;
  logic [31:0]        r_buf;

  logic               w_req;
  logic               w_last;
  logic               w_clear;
  logic               w_enable;
  logic [31:0]        w_off;
  logic               w_unused_off;
  logic               w_ready;
  logic [31:0]        w_result;
  logic [IDX_W:0]     w_sram_addr;
  logic [HALF_W-1:0]  w_dq_out;
  logic               w_we_n;
  logic               w_oe_n;

  assign w_req        = bus.mem_read | bus.mem_write;
  assign w_off        = bus.address - BASE_ADDR;
  assign w_unused_off = ^{w_off[31:IDX_W+2], w_off[1:0]};

  phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_data     <= '0;
      r_buf      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req) begin
        r_is_write <= bus.mem_write;
        r_idx      <= w_off[IDX_W+1:2];
        r_data     <= bus.data;
      end
      if (!r_is_write && w_last) begin
        if (r_state == ST_LOW)  r_buf[HALF_W-1:0]        <= bus.sram_dq_in;
        if (r_state == ST_HIGH) r_buf[2*HALF_W-1:HALF_W] <= bus.sram_dq_in;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    w_ready     = 1'b0;
    w_result    = '0;
    w_sram_addr = '0;
    w_dq_out    = '0;
    w_we_n      = 1'b1;
    w_oe_n      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        w_ready = !w_req;
        if (w_req) w_next = ST_LOW;
      end
      ST_LOW, ST_HIGH: begin
        w_enable    = 1'b1;
        w_sram_addr = {r_idx, (r_state == ST_HIGH)};
        if (r_is_write) begin
          w_we_n   = 1'b0;
          w_dq_out = (r_state == ST_HIGH) ? r_data[2*HALF_W-1:HALF_W] : r_data[HALF_W-1:0];
        end else begin
          w_oe_n = 1'b0;
        end
        if (w_last) w_next = (r_state == ST_HIGH) ? ST_DONE : ST_LOW;
        if (w_last && r_state == ST_LOW) w_next = ST_HIGH;
      end
      ST_DONE: begin
        w_clear = 1'b1;
        w_ready = 1'b1;
        if (!r_is_write) w_result = r_buf;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset aborts immediately: the edge that applies it must not strobe the SRAM.
    if (!rst) begin
      w_result    = '0;
      w_sram_addr = '0;
      w_dq_out    = '0;
      w_we_n      = 1'b1;
      w_oe_n      = 1'b1;
    end
  end

  assign bus.ready       = w_ready;
  assign bus.mem_result  = w_result;
  assign bus.sram_addr   = w_sram_addr;
  assign bus.sram_dq_out = w_dq_out;
  assign bus.sram_we_n   = w_we_n;
  assign bus.sram_oe_n   = w_oe_n;
  assign o_state         = r_state;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: vector table of word accesses plus reset corner sequences.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_result;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;

  logic   clk = 1'b0;
  logic   rst;
  state_t dut_state;
  int     n_tests = 0;
  int     n_fail  = 0;
  logic [15:0] sram_mem [128];
  vec_t   vecs [NV];

  sram_controller_if #(.SA_W(7)) bus ();

  sram_controller #(
    .BASE_ADDR   (32'd1024),
    .DEPTH_WORDS (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .o_state (dut_state)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: write on rising edge with we_n low, read is combinational.
  initial for (int i = 0; i < 128; i++) sram_mem[i] = 16'h0000;
  always @(posedge clk) if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0000 : sram_mem[bus.sram_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request held until ready, then returns just after the retiring edge.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat  = 0;
    int          leak = 0;
    logic [31:0] got  = 32'hFFFF_FFFF;
    bus.mem_write = v.wr;
    bus.mem_read  = v.rd;
    bus.address   = v.addr;
    bus.data      = v.wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (bus.ready) begin
        got = bus.mem_result;
        break;
      end
      if (bus.mem_result != 32'h0) leak++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_result"}, got, v.exp_result);
    check({tag, "_no_early_result"}, 32'(leak), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.address   = 32'h0;
    bus.data      = 32'h0;
  endtask

  initial begin
    vec_t tmp;
    logic found;
    vecs[0] = '{1'b1, 1'b0, 32'd1028,        32'hDEADBEEF, 32'h0,        6};
    vecs[1] = '{1'b0, 1'b1, 32'd1028,        32'h0,        32'hDEADBEEF, 6};
    vecs[2] = '{1'b1, 1'b0, 32'd1280,        32'h12345678, 32'h0,        6};
    vecs[3] = '{1'b0, 1'b1, 32'd1026,        32'h0,        32'h12345678, 6};
    vecs[4] = '{1'b0, 1'b1, 32'd1280,        32'h0,        32'h12345678, 6};
    vecs[5] = '{1'b1, 1'b1, 32'd1032,        32'hCAFEF00D, 32'h0,        6};
    vecs[6] = '{1'b0, 1'b1, 32'd1032,        32'h0,        32'hCAFEF00D, 6};
    vecs[7] = '{1'b1, 1'b0, 32'd1276,        32'hA5A55A5A, 32'h0,        6};
    vecs[8] = '{1'b0, 1'b1, 32'd1276,        32'h0,        32'hA5A55A5A, 6};
    vecs[9] = '{1'b0, 1'b1, 32'd1020,        32'h0,        32'hA5A55A5A, 6};

    // Reset held with a pending write: nothing may reach the SRAM.
    rst           = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.address   = 32'd1028;
    bus.data      = 32'h11112222;
    repeat (3) begin
      @(negedge clk);
      check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
      check("rst_result", bus.mem_result, 32'h0);
      check("rst_state", 32'(dut_state), 32'(ST_IDLE));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rel_idle_state", 32'(dut_state), 32'(ST_IDLE));
    check("rel_idle_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("rel_low_state", 32'(dut_state), 32'(ST_LOW));
    check("rel_low_we_n", 32'(bus.sram_we_n), 32'd0);
    check("rel_low_addr", 32'(bus.sram_addr), 32'd2);
    check("rel_low_dq", 32'(bus.sram_dq_out), 32'h2222);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        found = 1'b1;
        break;
      end
    end
    check("rel_completes", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    go_idle();
    @(negedge clk);
    check("rel_mem2", 32'(sram_mem[2]), 32'h2222);
    check("rel_mem3", 32'(sram_mem[3]), 32'h1111);
    check("idle_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;

    // Table of accesses issued back to back, as a frozen pipeline would.
    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    go_idle();
    @(negedge clk);
    check("mem0", 32'(sram_mem[0]), 32'h5678);
    check("mem1", 32'(sram_mem[1]), 32'h1234);
    check("mem2", 32'(sram_mem[2]), 32'hBEEF);
    check("mem3", 32'(sram_mem[3]), 32'hDEAD);
    check("mem4", 32'(sram_mem[4]), 32'hF00D);
    check("mem5", 32'(sram_mem[5]), 32'hCAFE);
    check("mem126", 32'(sram_mem[126]), 32'h5A5A);
    check("mem127", 32'(sram_mem[127]), 32'hA5A5);
    @(posedge clk);
    #1;

    // Reset during the first HIGH cycle of a write.
    tmp = '{1'b1, 1'b0, 32'd1044, 32'h77776666, 32'h0, 6};
    run_vec(tmp, "pre_abort");
    go_idle();
    @(posedge clk);
    #1;
    bus.mem_write = 1'b1;
    bus.address   = 32'd1044;
    bus.data      = 32'h99998888;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dut_state == ST_HIGH) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_high", 32'(found), 32'd1);
    check("abort_high_addr", 32'(bus.sram_addr), 32'd11);
    rst = 1'b0;
    go_idle();
    #1;
    check("abort_we_n_gated", 32'(bus.sram_we_n), 32'd1);
    @(posedge clk);
    #1;
    check("abort_state", 32'(dut_state), 32'(ST_IDLE));
    check("abort_we_n", 32'(bus.sram_we_n), 32'd1);
    check("abort_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("abort_addr", 32'(bus.sram_addr), 32'd0);
    check("abort_dq", 32'(bus.sram_dq_out), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_mem10", 32'(sram_mem[10]), 32'h8888);
    check("abort_mem11", 32'(sram_mem[11]), 32'h7777);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
